// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one sync_fifo write port among NUM_REQ producers.
// Optional packet lock via `FIFO_ARB_LOCK_EN (keeps multi-beat packets contiguous).
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_SIZE  = 8,
    localparam int CNTW      = $clog2(FIFO_SIZE) + 1,
    localparam int IDW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_last,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [CNTW-1:0]               fifo_count,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [IDW-1:0]                grant_id
);

    logic [IDW-1:0]        rr_last;
    logic [IDW-1:0]        win_id;
    logic                  any_win;
    logic                  space;
    logic                  grant;
    logic [CNTW:0]         occupancy;
    logic [NUM_REQ-1:0]    elig_valid;
    logic [DATA_WIDTH-1:0] win_data;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDW'(s);
    endfunction

    // In-flight registered write counts as occupied; FIFO reads are ignored (conservative).
    assign occupancy = {1'b0, fifo_count} + {{CNTW{1'b0}}, fifo_wr_en};
    assign space     = occupancy < (CNTW+1)'(FIFO_SIZE);

`ifdef FIFO_ARB_LOCK_EN
    // state  | meaning
    // IDLE   | arbitrate round-robin among all valid producers
    // LOCKED | packet in progress, only lock_id may be granted
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IDW-1:0] lock_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            lock_id <= '0;
        end else begin
            state <= state_nxt;
            if (grant && state == IDLE) lock_id <= win_id;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant && !req_last[win_id]) state_nxt = LOCKED;
            LOCKED:  if (grant && req_last[lock_id]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        elig_valid = req_valid;
        if (state == LOCKED) elig_valid = req_valid & (NUM_REQ'(1) << lock_id);
    end
`else
    assign elig_valid = req_valid;
`endif

    // Walk downwards so the nearest requester after rr_last overrides farther ones.
    always_comb begin
        win_id  = '0;
        any_win = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (elig_valid[rr_idx(rr_last, k)]) begin
                win_id  = rr_idx(rr_last, k);
                any_win = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == IDW'(i)) win_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign grant     = reset & space & any_win;
    assign req_ready = grant ? (NUM_REQ'(1) << win_id) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fifo_wr_en   <= 1'b0;
            fifo_data_in <= '0;
            grant_id     <= '0;
            rr_last      <= IDW'(NUM_REQ - 1);
        end else begin
            fifo_wr_en <= grant;
            if (grant) begin
                fifo_data_in <= win_data;
                grant_id     <= win_id;
                rr_last      <= win_id;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a behavioural model.
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int FS = 8;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
`ifdef FIFO_ARB_LOCK_EN
    logic [NR-1:0]   req_last;
`endif
    logic [NR-1:0]   req_ready;
    logic [CW-1:0]   fifo_count;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data_in;
    logic [1:0]      grant_id;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int         m_rr;
    int         m_grant;
    int         m_cnt;
    bit         m_wr;
    logic [7:0] m_data;
`ifdef FIFO_ARB_LOCK_EN
    bit         m_locked;
    int         m_lock_id;
`endif

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_SIZE(FS)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_data     (req_data),
`ifdef FIFO_ARB_LOCK_EN
        .req_last     (req_last),
`endif
        .req_ready    (req_ready),
        .fifo_count   (fifo_count),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id)
    );

    function automatic int pick(input logic [NR-1:0] v);
        logic [NR-1:0] e;
        e = v;
        if (m_cnt + int'(m_wr) >= FS) return -1;
`ifdef FIFO_ARB_LOCK_EN
        if (m_locked) e = v & (4'b0001 << m_lock_id);
`endif
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (m_rr + k) % NR;
            if (e[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] exp_ready(input logic [NR-1:0] v);
        int w;
        w = pick(v);
        return (w < 0) ? 4'b0000 : 4'(1 << w);
    endfunction

    task automatic model_reset();
        m_rr = NR - 1; m_grant = 0; m_wr = 0; m_data = 8'h00; m_cnt = 0;
`ifdef FIFO_ARB_LOCK_EN
        m_locked = 0; m_lock_id = 0;
`endif
        fifo_count = '0;
    endtask

    // Advance one clock edge, updating the model from the pre-edge inputs.
    task automatic tick(input bit rd);
        int w;
        w = pick(req_valid);
        @(posedge clk);
        m_cnt = m_cnt + int'(m_wr) - ((rd && m_cnt > 0) ? 1 : 0);
        if (w >= 0) begin
            m_wr = 1; m_data = req_data[w*DW +: DW]; m_grant = w; m_rr = w;
`ifdef FIFO_ARB_LOCK_EN
            if (!m_locked && !req_last[w]) begin
                m_locked = 1; m_lock_id = w;
            end else if (m_locked && req_last[w]) begin
                m_locked = 0;
            end
`endif
        end else begin
            m_wr = 0;
        end
        #1 fifo_count = CW'(m_cnt);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req_valid = '0;
`ifdef FIFO_ARB_LOCK_EN
        req_last = '1;
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 4'hF; req_data = $urandom; fifo_count = '0;
`ifdef FIFO_ARB_LOCK_EN
        req_last = '1;
`endif
        model_reset();
        #3;
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
        total++; if (fifo_data_in !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", fifo_data_in); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d exp=0", grant_id); end
        @(negedge clk);
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        reset = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        apply_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            total++; if (req_ready !== 4'(1 << (j % 4))) begin bad++; $display("FAIL rr_ready j=%0d got=%b exp=%b", j, req_ready, 4'(1 << (j % 4))); end
            tick(0);
            total++; if (fifo_wr_en !== 1'b1) begin bad++; $display("FAIL rr_wr_en j=%0d got=%b exp=1", j, fifo_wr_en); end
            total++; if (fifo_data_in !== 8'(8'hA0 + j % 4)) begin bad++; $display("FAIL rr_data j=%0d got=%h exp=%h", j, fifo_data_in, 8'(8'hA0 + j % 4)); end
            total++; if (grant_id !== 2'(j % 4)) begin bad++; $display("FAIL rr_grant j=%0d got=%0d exp=%0d", j, grant_id, j % 4); end
        end
    endtask

    task automatic test_full_guard();
        int accepts;
        apply_reset();
        accepts = 0;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            req_valid = 4'b0001; req_data = $urandom;
            #1;
            total++; if (req_ready !== exp_ready(req_valid)) begin bad++; $display("FAIL full_ready j=%0d got=%b exp=%b", j, req_ready, exp_ready(req_valid)); end
            if (req_ready[0]) accepts++;
            tick(0);
            if (fifo_count == CW'(FS)) begin
                total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL full_overflow j=%0d got=%b exp=0", j, fifo_wr_en); end
            end
        end
        total++; if (accepts != FS) begin bad++; $display("FAIL full_accepts got=%0d exp=%0d", accepts, FS); end
        #1;
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL full_final_ready got=%b exp=0000", req_ready); end
    endtask

    task automatic test_in_flight();
        logic [3:0] exp_r0;
        apply_reset();
        exp_r0 = 4'b0011;
        m_cnt = 6; fifo_count = 4'd6;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            req_valid = 4'b0001;
            #1;
            total++; if (req_ready[0] !== exp_r0[j]) begin bad++; $display("FAIL inflight_ready j=%0d count=%0d wr_en=%b got=%b exp=%b", j, fifo_count, fifo_wr_en, req_ready[0], exp_r0[j]); end
            total++; if (req_ready !== exp_ready(req_valid)) begin bad++; $display("FAIL inflight_model j=%0d got=%b exp=%b", j, req_ready, exp_ready(req_valid)); end
            tick(0);
        end
    endtask

    task automatic test_fairness();
        int exp_g [6];
        exp_g = '{0, 2, 0, 2, 0, 1};
        apply_reset();
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            req_valid = (j < 5) ? 4'b0101 : 4'b0111;
            req_data = $urandom;
            #1;
            tick(1);
            total++; if (fifo_wr_en !== 1'b1 || grant_id !== 2'(exp_g[j])) begin bad++; $display("FAIL fair_grant j=%0d got=%0d/%b exp=%0d/1", j, grant_id, fifo_wr_en, exp_g[j]); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            req_data = $urandom | 32'h0101_0101;
            tick(0);
        end
        #2 reset = 1'b0;
        #1;
        total++; if (fifo_wr_en !== 1'b0) begin bad++; $display("FAIL areset_wr_en got=%b exp=0", fifo_wr_en); end
        total++; if (fifo_data_in !== 8'h00) begin bad++; $display("FAIL areset_data got=%h exp=00", fifo_data_in); end
        total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL areset_ready got=%b exp=0000", req_ready); end
        model_reset();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL areset_first_ready got=%b exp=0001", req_ready); end
        tick(0);
        total++; if (grant_id !== 2'd0 || fifo_data_in !== req_data[7:0]) begin bad++; $display("FAIL areset_first_grant got=%0d/%h exp=0/%h", grant_id, fifo_data_in, req_data[7:0]); end
    endtask

`ifdef FIFO_ARB_LOCK_EN
    task automatic test_packet_lock();
        int exp_g [4];
        exp_g = '{1, 1, 1, 0};
        apply_reset();
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            req_valid = (j == 0) ? 4'b0010 : 4'b0011;
            req_last  = (j == 2) ? 4'b0011 : 4'b0001;
            req_data  = {8'h00, 8'h00, 8'(8'h10 + j), 8'hF0};
            #1;
            total++; if (req_ready !== 4'(1 << exp_g[j])) begin bad++; $display("FAIL lock_ready j=%0d got=%b exp=%b", j, req_ready, 4'(1 << exp_g[j])); end
            tick(1);
            total++; if (grant_id !== 2'(exp_g[j]) || fifo_wr_en !== 1'b1) begin bad++; $display("FAIL lock_grant j=%0d got=%0d exp=%0d", j, grant_id, exp_g[j]); end
        end
    endtask
`endif

    task automatic test_random();
        bit rd;
        apply_reset();
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            req_valid = 4'($urandom);
            req_data  = $urandom;
`ifdef FIFO_ARB_LOCK_EN
            req_last  = 4'($urandom);
`endif
            rd = 1'($urandom_range(0, 1));
            #1;
            total++; if (req_ready !== exp_ready(req_valid)) begin bad++; $display("FAIL rand_ready j=%0d got=%b exp=%b", j, req_ready, exp_ready(req_valid)); end
            tick(rd);
            total++; if (fifo_wr_en !== m_wr) begin bad++; $display("FAIL rand_wr_en j=%0d got=%b exp=%b", j, fifo_wr_en, m_wr); end
            total++; if (fifo_data_in !== m_data) begin bad++; $display("FAIL rand_data j=%0d got=%h exp=%h", j, fifo_data_in, m_data); end
            total++; if (grant_id !== 2'(m_grant)) begin bad++; $display("FAIL rand_grant j=%0d got=%0d exp=%0d", j, grant_id, m_grant); end
        end
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0;
        req_data = '0;
        fifo_count = '0;
`ifdef FIFO_ARB_LOCK_EN
        req_last = '1;
`endif
        test_reset();
        test_round_robin();
        test_full_guard();
        test_in_flight();
        test_fairness();
        test_async_reset();
`ifdef FIFO_ARB_LOCK_EN
        test_packet_lock();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
